rotator_apply: RTL
==================

Name: rotator_apply

Overview:
Consumer end of the Rotator16 twiddle interface. It buffers incoming complex samples of a frame and, when the rotator asserts triger, pairs each buffered sample with the rotator_real/rotator_img value presented that cycle. Each pair goes through a pipelined complex multiplier with rounding and saturation. The block sits between an FFT butterfly stage and the next stage; Rotator16 drives its rotator inputs.

Parameters:
DW, 18, sample and output width (signed, two's complement)
RW, 18, rotator width (signed Q1.16; +1.0 = 65536)
N, 16, rotator values per triger (points per frame)
DEPTH, 16, sample FIFO depth (power of 2, >= N)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-low
din_valid  in  1  sample valid
din_real  in  DW  sample real part
din_img  in  DW  sample imaginary part
triger  in  1  one-cycle pulse from Rotator16, coincident with the first rotator value of a run
rotator_real  in  RW  twiddle real part; valid every cycle of a run
rotator_img  in  RW  twiddle imaginary part
dout_valid  out  1  product valid
dout_start  out  1  high with the first product of each run
dout_real  out  DW  product real part
dout_img  out  DW  product imaginary part
err_ovf  out  1  sticky: write attempted while FIFO full
err_udf  out  1  sticky: run cycle with FIFO empty
err_trig  out  1  sticky: triger received while in RUN

Behaviour:
- Reset (rst=0 at a clock edge): FIFO emptied, state IDLE, run counter 0, pipeline valids cleared. All outputs are 0 in the cycle after reset.
- FIFO write: on din_valid=1 when not full. When full, the sample is dropped and err_ovf is set. Write and pop in the same cycle while full is legal; the count is unchanged and nothing is dropped.
- FSM has two states:
  - IDLE: triger=1 moves to RUN with cnt=0, and that same cycle is run cycle 0.
  - RUN: each cycle pops one sample (if the FIFO is non-empty) and pairs it with the current rotator inputs; cnt increments. After cnt=N-1 the FSM returns to IDLE.
  - triger=1 in RUN is ignored and sets err_trig.
  - triger on the cycle after cnt=N-1 (FSM already IDLE) starts a new run normally.
- Underrun: a run cycle with the FIFO empty sets err_udf. That rotator value is discarded, no product is issued, and cnt still advances.
- Multiplier pipeline, latency 3 cycles from pop to dout_valid:
  - Stage 1: register sample a+jb and rotator c+jd.
  - Stage 2: four signed products (DW+RW bits); sums re = ac - bd, im = ad + bc, carried at DW+RW+1 bits.
  - Stage 3: add 2^15 (round half up), arithmetic shift right 16, saturate to [-2^(DW-1), 2^(DW-1)-1]; register the outputs.
- dout_start marks the product from run cycle 0 only if that cycle popped. If cycle 0 underran, dout_start goes with the first valid product of the run.
- When dout_valid=0, dout_real and dout_img hold their last values.
- Error flags are cleared only by reset.
- Reset mid-run aborts the run. In-flight products are discarded, and outputs are 0 on the next cycle.

Test Plan:
1. Identity: 16 samples din=(1000,0) then triger, rotator held at (65536,0) -> 16 outputs of (1000,0); dout_valid first high 3 cycles after triger; dout_start on the first only.
2. Quarter turn: din=(1000,500), rotator=(0,-65536) -> dout=(500,-1000). Eighth turn: din=(10000,0), rotator=(46341,-46341) -> dout=(7071,-7071).
3. Saturation: din=(131071,131071), rotator=(65536,65536) -> dout=(0,131071). Negative case: din=(-131072,0), rotator=(65536,0) -> (-131072,0).
4. Flow: 17 samples written with no pop -> the 17th is dropped and err_ovf=1. Triger with 10 samples buffered -> 10 products, err_udf=1.
5. Back-to-back: two runs with triger spaced exactly 16 cycles apart -> 32 contiguous products, dout_start at outputs 0 and 16, err_trig=0. A triger at run cycle 5 -> err_trig=1 and the run still completes with 16 products.
6. Reset mid-run at cycle 8 -> dout_valid=0 the next cycle, FIFO empty, flags 0. A fresh run afterwards produces correct results.

Source files
------------

// File: rtl/rotator_apply.sv
// Consumer side of the Rotator16 twiddle interface: buffers frame samples and
// multiplies each one by the twiddle presented during a triger-initiated run.
module rotator_apply #(
  parameter int unsigned DW    = 18,
  parameter int unsigned RW    = 18,
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [DW-1:0] din_real,
  input  logic [DW-1:0] din_img,
  input  logic          triger,
  input  logic [RW-1:0] rotator_real,
  input  logic [RW-1:0] rotator_img,
  output logic          dout_valid,
  output logic          dout_start,
  output logic [DW-1:0] dout_real,
  output logic [DW-1:0] dout_img,
  output logic          err_ovf,
  output logic          err_udf,
  output logic          err_trig
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned NW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW   = DW + RW;
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned FRAC = 16;
  localparam int unsigned TW   = SW - FRAC;
  localparam int          RND     = 1 <<< (FRAC - 1);
  localparam int          SAT_MAX = (1 <<< (DW - 1)) - 1;
  localparam int          SAT_MIN = -(1 <<< (DW - 1));

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   run_cnt_q, run_cnt_d;
  logic            run_cyc_c, run_start_c, trig_err_c;

  logic [DW-1:0]   mem_re_q [DEPTH];
  logic [DW-1:0]   mem_im_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty_c, full_c, pop_c, wr_c;
  logic            need_start_q, need_start_d;

  logic                 s1_valid_q, s1_valid_d, s1_start_q, s1_start_d;
  logic signed [DW-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic signed [RW-1:0] s1_c_q, s1_c_d, s1_d_q, s1_d_d;
  logic                 s2_valid_q, s2_valid_d, s2_start_q, s2_start_d;
  logic signed [SW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;

  logic          dout_valid_q, dout_valid_d, dout_start_q, dout_start_d;
  logic [DW-1:0] dout_real_q, dout_real_d, dout_img_q, dout_img_d;
  logic          err_ovf_q, err_ovf_d, err_udf_q, err_udf_d, err_trig_q, err_trig_d;

  // Round half up at the Q1.16 point, then clamp to the output range.
  function automatic logic [DW-1:0] round_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] r;
    logic signed [TW-1:0] t;
    r = v + SW'(RND);
    t = r[SW-1:FRAC];
    if (t > TW'(SAT_MAX))      round_sat = DW'(SAT_MAX);
    else if (t < TW'(SAT_MIN)) round_sat = DW'(SAT_MIN);
    else                       round_sat = DW'(t);
  endfunction

  // Run FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Run FSM: next state; the triger cycle itself is run cycle 0
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      IDLE: begin
        if (triger) begin
          state_d   = RUN;
          run_cnt_d = NW'(1);
        end
      end
      default: begin
        if (run_cnt_q == NW'(N - 1)) begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + NW'(1);
        end
      end
    endcase
  end

  // Run FSM: outputs
  always_comb begin
    run_cyc_c   = (state_q == RUN) || triger;
    run_start_c = (state_q == IDLE) && triger;
    trig_err_c  = (state_q == RUN) && triger;
  end

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CW'(DEPTH));
  assign pop_c   = run_cyc_c && !empty_c;
  assign wr_c    = din_valid && (!full_c || pop_c);

  always_comb begin
    p_ac = PW'(s1_a_q) * PW'(s1_c_q);
    p_bd = PW'(s1_b_q) * PW'(s1_d_q);
    p_ad = PW'(s1_a_q) * PW'(s1_d_q);
    p_bc = PW'(s1_b_q) * PW'(s1_c_q);
  end

  // FIFO bookkeeping, multiplier pipeline and sticky error flags
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    need_start_d = need_start_q;
    s1_valid_d   = pop_c;
    s1_start_d   = pop_c && (run_start_c || need_start_q);
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_c_d       = s1_c_q;
    s1_d_d       = s1_d_q;
    s2_valid_d   = s1_valid_q;
    s2_start_d   = s1_valid_q && s1_start_q;
    s2_re_d      = SW'(p_ac) - SW'(p_bd);
    s2_im_d      = SW'(p_ad) + SW'(p_bc);
    dout_valid_d = s2_valid_q;
    dout_start_d = s2_valid_q && s2_start_q;
    dout_real_d  = dout_real_q;
    dout_img_d   = dout_img_q;
    err_ovf_d    = err_ovf_q || (din_valid && full_c && !pop_c);
    err_udf_d    = err_udf_q || (run_cyc_c && empty_c);
    err_trig_d   = err_trig_q || trig_err_c;

    if (wr_c)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // dout_start follows the first product actually issued in a run
    if (run_start_c) need_start_d = 1'b1;
    if (pop_c)       need_start_d = 1'b0;

    if (pop_c) begin
      s1_a_d = mem_re_q[rd_ptr_q];
      s1_b_d = mem_im_q[rd_ptr_q];
      s1_c_d = rotator_real;
      s1_d_d = rotator_img;
    end

    if (s2_valid_q) begin
      dout_real_d = round_sat(s2_re_q);
      dout_img_d  = round_sat(s2_im_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem_re_q[wr_ptr_q] <= din_real;
      mem_im_q[wr_ptr_q] <= din_img;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      need_start_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_start_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_c_q       <= '0;
      s1_d_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_start_q   <= 1'b0;
      s2_re_q      <= '0;
      s2_im_q      <= '0;
      dout_valid_q <= 1'b0;
      dout_start_q <= 1'b0;
      dout_real_q  <= '0;
      dout_img_q   <= '0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
      err_trig_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      need_start_q <= need_start_d;
      s1_valid_q   <= s1_valid_d;
      s1_start_q   <= s1_start_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_c_q       <= s1_c_d;
      s1_d_q       <= s1_d_d;
      s2_valid_q   <= s2_valid_d;
      s2_start_q   <= s2_start_d;
      s2_re_q      <= s2_re_d;
      s2_im_q      <= s2_im_d;
      dout_valid_q <= dout_valid_d;
      dout_start_q <= dout_start_d;
      dout_real_q  <= dout_real_d;
      dout_img_q   <= dout_img_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
      err_trig_q   <= err_trig_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_start = dout_start_q;
  assign dout_real  = dout_real_q;
  assign dout_img   = dout_img_q;
  assign err_ovf    = err_ovf_q;
  assign err_udf    = err_udf_q;
  assign err_trig   = err_trig_q;

endmodule
